plab5_mcore_mem_req_msg_pack_queue: RTL

- Parametrised successor to the combinational memory request control packer.
- Packs type/opaque/addr/len/data fields into a complete memory request message and holds the result in a depth-configurable FIFO.
- Val/rdy handshake on both sides; each entry carries a security-domain tag.
- Sits between a core's memory-request source and the memory network/cache port, decoupling field generation from downstream backpressure.

---
 rtl/plab5_mcore_mem_req_msg_pack_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/plab5_mcore_mem_req_msg_pack_queue.sv
// Memory request message packer followed by a depth-configurable val/rdy FIFO with a per-entry domain tag.
// Optional domain fence enabled by defining PLAB5_MCORE_MEM_REQ_PACK_DOMAIN_FENCE_EN.
module plab5_mcore_mem_req_msg_pack_queue #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_num_entries  = 2,
  localparam int c_t  = 3,
  localparam int c_l  = (p_data_nbits / 8 > 1) ? $clog2(p_data_nbits / 8) : 1,
  localparam int c_c  = c_t + p_opaque_nbits + p_addr_nbits + c_l + p_data_nbits,
  localparam int c_cw = $clog2(p_num_entries + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [c_t-1:0]            in_type,
  input  logic [p_opaque_nbits-1:0] in_opaque,
  input  logic [p_addr_nbits-1:0]   in_addr,
  input  logic [c_l-1:0]            in_len,
  input  logic [p_data_nbits-1:0]   in_data,
  input  logic                      in_domain,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [c_c-1:0]            out_msg,
  output logic                      out_domain,
  output logic [c_cw-1:0]           count
);

  localparam int c_pw = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

  logic [c_c-1:0]          r_msg [p_num_entries];
  logic                    r_dom [p_num_entries];
  logic [c_pw-1:0]         r_head;
  logic [c_pw-1:0]         r_tail;
  logic [c_cw-1:0]         r_count;

  logic                    w_full;
  logic                    w_enq;
  logic                    w_deq;
  logic [p_data_nbits-1:0] w_data_field;
  logic [c_c-1:0]          w_packed;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] ptr);
    return (ptr == c_pw'(p_num_entries - 1)) ? '0 : ptr + c_pw'(1);
  endfunction

  assign w_full       = (r_count == c_cw'(p_num_entries));
  assign w_data_field = (in_type == 3'd0) ? '0 : in_data;
  assign w_packed     = {in_type, in_opaque, in_addr, in_len, w_data_field};
  assign w_enq        = in_val && in_rdy;
  assign w_deq        = out_val && out_rdy;

`ifdef PLAB5_MCORE_MEM_REQ_PACK_DOMAIN_FENCE_EN
  logic r_last_domain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_domain <= 1'b0;
    end else if (w_enq) begin
      r_last_domain <= in_domain;
    end
  end

  // A domain switch waits for a full drain so the queue never mixes domains.
  assign in_rdy = !w_full && ((r_count == '0) || (in_domain == r_last_domain));
`else
  assign in_rdy = !w_full;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= f_next(r_tail);
      end
      if (w_deq) begin
        r_head <= f_next(r_head);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_msg[r_tail] <= w_packed;
      r_dom[r_tail] <= in_domain;
    end
  end

  assign out_val    = (r_count != '0);
  assign out_msg    = r_msg[r_head];
  assign out_domain = r_dom[r_head];
  assign count      = r_count;

endmodule
